load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
`default_nettype none
// load_store_unit_if: pipeline request/response channel plus the data-memory port of the load/store unit.
// The slave modport is the unit's view; master is the surrounding pipeline and memory.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_read, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_read, mem_wr, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit: RV32I byte/half/word loads and stores against a word-wide data memory.
// Sub-word stores are read-modify-write; illegal, misaligned or out-of-range requests only return resp_err.
module load_store_unit #(
   parameter int NUM_WORDS = 32
) (
   input  wire logic        clk,
   input  wire logic        n_rst,
   load_store_unit_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      RD_WAIT = 3'd2,
      WR      = 3'd3,
      RESP    = 3'd4
   } state_t;

   localparam logic [2:0] c_F3_B  = 3'b000;
   localparam logic [2:0] c_F3_H  = 3'b001;
   localparam logic [2:0] c_F3_W  = 3'b010;
   localparam logic [2:0] c_F3_BU = 3'b100;
   localparam logic [2:0] c_F3_HU = 3'b101;

   state_t      state_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [15:0] wdata_q;
   logic        req_ready_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;
   logic        mem_read_q;
   logic        mem_wr_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;

   logic        legal_d;
   logic        misalign_d;
   logic        range_d;
   logic        err_d;
   logic [7:0]  byte_d;
   logic [15:0] half_d;
   logic [31:0] load_d;
   logic [31:0] merge_d;

   // Request classification, evaluated on the live request fields at acceptance.
   always_comb begin
      if (bus.req_we) begin
         legal_d = (bus.req_funct3 == c_F3_B) || (bus.req_funct3 == c_F3_H) ||
                   (bus.req_funct3 == c_F3_W);
      end else begin
         legal_d = (bus.req_funct3 == c_F3_B)  || (bus.req_funct3 == c_F3_H) ||
                   (bus.req_funct3 == c_F3_W)  || (bus.req_funct3 == c_F3_BU) ||
                   (bus.req_funct3 == c_F3_HU);
      end
      case (bus.req_funct3[1:0])
         2'b01:   misalign_d = bus.req_addr[0];
         2'b10:   misalign_d = |bus.req_addr[1:0];
         default: misalign_d = 1'b0;
      endcase
      range_d = {2'b00, bus.req_addr[31:2]} >= 32'(NUM_WORDS);
      err_d   = !legal_d || misalign_d || range_d;
   end

   // Lane extraction for loads and lane merge for sub-word stores, both from the registered read word.
   always_comb begin
      byte_d = bus.mem_rdata[{off_q, 3'b000} +: 8];
      half_d = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (funct3_q)
         c_F3_B:  load_d = {{24{byte_d[7]}}, byte_d};
         c_F3_H:  load_d = {{16{half_d[15]}}, half_d};
         c_F3_BU: load_d = {24'd0, byte_d};
         c_F3_HU: load_d = {16'd0, half_d};
         default: load_d = bus.mem_rdata;
      endcase
      merge_d = bus.mem_rdata;
      if (funct3_q == c_F3_B) begin
         merge_d[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merge_d[{off_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'd0;
         off_q        <= 2'd0;
         wdata_q      <= 16'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
         mem_read_q   <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  we_q        <= bus.req_we;
                  funct3_q    <= bus.req_funct3;
                  off_q       <= bus.req_addr[1:0];
                  wdata_q     <= bus.req_wdata[15:0];
                  req_ready_q <= 1'b0;
                  if (err_d) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'd0;
                  end else begin
                     mem_addr_q <= {2'b00, bus.req_addr[31:2]};
                     if (bus.req_we && (bus.req_funct3 == c_F3_W)) begin
                        state_q     <= WR;
                        mem_wr_q    <= 1'b1;
                        mem_wdata_q <= bus.req_wdata;
                     end else begin
                        state_q    <= RD;
                        mem_read_q <= 1'b1;
                     end
                  end
               end
            end
            RD: begin
               mem_read_q <= 1'b0;
               state_q    <= RD_WAIT;
            end
            RD_WAIT: begin
               // mem_rdata is valid here: the memory registers it one cycle after mem_read.
               if (we_q) begin
                  mem_wdata_q <= merge_d;
                  mem_wr_q    <= 1'b1;
                  state_q     <= WR;
               end else begin
                  resp_rdata_q <= load_d;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  state_q      <= RESP;
               end
            end
            WR: begin
               mem_wr_q     <= 1'b0;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= 32'd0;
               state_q      <= RESP;
            end
            RESP: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               req_ready_q  <= 1'b1;
               state_q      <= IDLE;
            end
            default: begin
               mem_read_q  <= 1'b0;
               mem_wr_q    <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_read   = mem_read_q;
   assign bus.mem_wr     = mem_wr_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// tb_load_store_unit: directed and randomized requests checked against a word-array reference model.
module tb_load_store_unit;
   localparam int NW = 32;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   int   tests = 0;
   int   fails = 0;

   load_store_unit_if bus ();

   load_store_unit #(.NUM_WORDS(NW)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem      [NW];
   logic [31:0] init_val [NW];
   logic [31:0] ref_mem  [NW];
   logic        init_req = 1'b0;
   logic [31:0] last_rdata;

   // Data memory: synchronous write, registered read valid the cycle after mem_read.
   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < NW; i++) mem[i] <= init_val[i];
      end else if (bus.mem_wr && bus.mem_addr < NW) begin
         mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
      end
      if (bus.mem_read)
         bus.mem_rdata <= (bus.mem_addr < NW) ? mem[bus.mem_addr[4:0]] : 32'hxxxx_xxxx;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: byte-addressed view of a word array, updating ref_mem for legal stores.
   function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                                 input bit [31:0] wd, output bit err, output bit [31:0] rd,
                                 output int lat, output int wcyc, output bit [31:0] nw,
                                 output int nrd);
      int size, o, idx;
      bit legal;
      bit [31:0] word, mask;
      o   = int'(a % 4);
      idx = int'(a / 4);
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         default:    size = 4;
      endcase
      legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
      err   = !legal || (o % size != 0) || (idx >= NW);
      rd = 0; nw = 0; wcyc = 0; nrd = 0; lat = 1;
      if (err) return;
      word = ref_mem[idx];
      if (!we) begin
         lat = 3; nrd = 1;
         if (size == 4) rd = word;
         else begin
            mask = (size == 1) ? 32'hFF : 32'hFFFF;
            rd   = (word >> (8 * o)) & mask;
            if (f3 < 3'd4 && rd > (mask >> 1)) rd = rd | ~mask;
         end
      end else if (size == 4) begin
         lat = 2; wcyc = 1; nw = wd;
         ref_mem[idx] = wd;
      end else begin
         lat = 4; wcyc = 3; nrd = 1;
         mask = ((size == 1) ? 32'hFF : 32'hFFFF) << (8 * o);
         nw   = (word & ~mask) | ((wd << (8 * o)) & mask);
         ref_mem[idx] = nw;
      end
   endfunction

   // Issue one request from a negedge, track strobes until resp_valid, compare with the model.
   task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit hold);
      bit e_err; bit [31:0] e_rd, e_nw; int e_lat, e_wcyc, e_nrd;
      int cyc, rd_cnt, wr_cnt, wr_cyc, both;
      logic [31:0] wr_data, wr_addr;
      bit got;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      for (int w = 0; w < 20 && bus.req_ready !== 1'b1; w++) @(negedge clk);
      check("ready_wait", bus.req_ready, 32'd1);
      model(we, f3, a, wd, e_err, e_rd, e_lat, e_wcyc, e_nw, e_nrd);
      @(posedge clk);
      cyc = 0; rd_cnt = 0; wr_cnt = 0; wr_cyc = 0; both = 0; got = 0;
      wr_data = 0; wr_addr = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (bus.mem_read === 1'b1) rd_cnt++;
         if (bus.mem_wr === 1'b1) begin
            wr_cnt++; wr_cyc = cyc; wr_data = bus.mem_wdata; wr_addr = bus.mem_addr;
         end
         if (bus.mem_read === 1'b1 && bus.mem_wr === 1'b1) both++;
         if (bus.resp_valid === 1'b1) got = 1;
      end
      check("resp_latency", cyc, e_lat);
      check("resp_err", bus.resp_err, {31'd0, e_err});
      check("resp_rdata", bus.resp_rdata, e_rd);
      check("ready_in_resp", bus.req_ready, 32'd0);
      check("rd_strobes", rd_cnt, e_nrd);
      check("wr_strobes", wr_cnt, (e_wcyc != 0) ? 32'd1 : 32'd0);
      check("both_strobes", both, 32'd0);
      if (e_wcyc != 0) begin
         check("wr_cycle", wr_cyc, e_wcyc);
         check("wr_data", wr_data, e_nw);
         check("wr_addr", wr_addr, a >> 2);
         check("mem_word", mem[a[6:2]], ref_mem[a[6:2]]);
      end
      last_rdata = bus.resp_rdata;
      if (!hold) bus.req_valid = 1'b0;
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      for (int i = 0; i < NW; i++) begin
         init_val[i] = $urandom;
         ref_mem[i]  = init_val[i];
      end

      repeat (2) @(negedge clk);
      check("rst_resp_valid", bus.resp_valid, 32'd0);
      check("rst_resp_err", bus.resp_err, 32'd0);
      check("rst_mem_read", bus.mem_read, 32'd0);
      check("rst_mem_wr", bus.mem_wr, 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      n_rst    = 1'b1;
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      check("ready_after_rst", bus.req_ready, 32'd1);

      do_req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 1'b0);
      check("sw_word2", mem[2], 32'hDEADBEEF);
      do_req(1'b0, 3'b010, 32'h8, 32'h0, 1'b0);
      check("lw_0x8", last_rdata, 32'hDEADBEEF);
      do_req(1'b0, 3'b000, 32'hB, 32'h0, 1'b0);
      check("lb_0xb", last_rdata, 32'hFFFFFFDE);
      do_req(1'b0, 3'b100, 32'hB, 32'h0, 1'b0);
      check("lbu_0xb", last_rdata, 32'h000000DE);
      do_req(1'b0, 3'b001, 32'hA, 32'h0, 1'b0);
      check("lh_0xa", last_rdata, 32'hFFFFDEAD);
      do_req(1'b0, 3'b101, 32'h8, 32'h0, 1'b0);
      check("lhu_0x8", last_rdata, 32'h0000BEEF);
      do_req(1'b1, 3'b000, 32'h9, 32'h55, 1'b0);
      check("sb_word2", mem[2], 32'hDEAD55EF);

      do_req(1'b0, 3'b010, 32'h6, 32'h0, 1'b0);
      do_req(1'b0, 3'b001, 32'h3, 32'h0, 1'b0);
      do_req(1'b0, 3'b011, 32'h8, 32'h0, 1'b0);
      do_req(1'b0, 3'b010, 32'h80, 32'h0, 1'b0);
      do_req(1'b1, 3'b100, 32'h4, 32'h0, 1'b0);

      // Reset while the SW sits in WR: the write must never land.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h14;
      bus.req_wdata  = 32'h12345678;
      check("rst_wr_ready", bus.req_ready, 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("rst_wr_in_wr", bus.mem_wr, 32'd1);
      n_rst = 1'b0;
      #1;
      check("rst_wr_drop", bus.mem_wr, 32'd0);
      check("rst_wr_resp", bus.resp_valid, 32'd0);
      check("rst_wr_addr", bus.mem_addr, 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      check("rst_wr_ready_rel", bus.req_ready, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_wr_no_resp", bus.resp_valid, 32'd0);
      end
      check("rst_wr_mem", mem[5], ref_mem[5]);

      do_req(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 1'b1);
      do_req(1'b0, 3'b010, 32'h40, 32'h0, 1'b1);
      do_req(1'b0, 3'b100, 32'h43, 32'h0, 1'b1);
      do_req(1'b0, 3'b110, 32'h40, 32'h0, 1'b1);
      do_req(1'b1, 3'b001, 32'h42, 32'h9A7B, 1'b1);
      do_req(1'b0, 3'b001, 32'h42, 32'h0, 1'b0);
      check("b2b_lh", last_rdata, 32'hFFFF9A7B);

      for (int k = 0; k < 80; k++) begin
         bit        rw;
         bit [2:0]  rf;
         bit [31:0] ra;
         rw = 1'($urandom_range(0, 1));
         rf = 3'($urandom_range(0, 7));
         ra = $urandom_range(0, NW * 4 + 7);
         if ($urandom_range(0, 1) == 1) ra = ra & ~32'h3;
         if ($urandom_range(0, 15) == 0) ra = $urandom;
         do_req(rw, rf, ra, $urandom, 1'($urandom_range(0, 1)));
         if (!bus.req_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.req_valid = 1'b0;

      for (int i = 0; i < NW; i++) check("final_mem", mem[i], ref_mem[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
